// File: rtl/dpc_sequencer.sv
// DekatronPC control sequencer: fetch from the IP line, dispatch to the AP/data line and I/O unit.
// Optional retired-instruction counter output IRET is enabled by defining DPC_IRET_EN.
module dpc_sequencer #(
    parameter int unsigned INSN_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned STEP_WIDTH = 8,
    parameter int unsigned TIMEOUT_W  = 10
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Halt,
    input  logic                  Step,
    input  logic                  Run,
    input  logic [STEP_WIDTH-1:0] StepCount,
    input  logic                  BpEn,
    input  logic [ADDR_WIDTH-1:0] BpAddr,
    input  logic [ADDR_WIDTH-1:0] IpAddress,
    output logic                  IpRequest,
    input  logic                  IpReady,
    input  logic [INSN_WIDTH-1:0] Insn,
    input  logic                  DataZero,
    input  logic                  ApZero,
    output logic                  DataRequest,
    output logic                  ApRequest,
    output logic                  Dec,
    input  logic                  ExecReady,
    output logic                  IoRequest,
    output logic                  IoDir,
    input  logic                  IoReady,
    output logic                  InsnMode,
    output logic [2:0]            State,
    output logic                  Cout,
    output logic                  BpHit,
    output logic                  Fault
`ifdef DPC_IRET_EN
    ,
    output logic [31:0]           IRET
`endif
);

    typedef enum logic [2:0] {
        StIdle  = 3'b001,
        StFetch = 3'b010,
        StExec  = 3'b011,
        StHalt  = 3'b100,
        StFault = 3'b101
    } state_e;

    // What EXEC waits on before it retires the instruction.
    typedef enum logic [1:0] {
        CmpNow  = 2'd0,
        CmpExec = 2'd1,
        CmpIo   = 2'd2
    } cmp_e;

    localparam logic [STEP_WIDTH-1:0] StepOne  = STEP_WIDTH'(1);
    localparam logic [TIMEOUT_W-1:0]  WdogOne  = TIMEOUT_W'(1);
    localparam logic [TIMEOUT_W-1:0]  WdogLast = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_e                r_state, w_state_d;
    cmp_e                  r_kind, w_kind_d;
    logic                  r_ip_req, w_ip_req_d;
    logic                  r_data_req, w_data_req_d;
    logic                  r_ap_req, w_ap_req_d;
    logic                  r_io_req, w_io_req_d;
    logic                  r_dec, w_dec_d;
    logic                  r_io_dir, w_io_dir_d;
    logic                  r_mode, w_mode_d;
    logic                  r_cout, w_cout_d;
    logic                  r_bp_hit, w_bp_hit_d;
    logic                  r_bp_skip, w_bp_skip_d;
    logic                  r_fault, w_fault_d;
    logic [STEP_WIDTH-1:0] r_steps, w_steps_d;
    logic [TIMEOUT_W-1:0]  r_wdog, w_wdog_d;
    logic                  w_wait;
    logic                  w_loop_zero;
    logic                  w_done;

    assign w_loop_zero = r_mode ? DataZero : ApZero;
    assign w_done      = (r_kind == CmpNow) || ((r_kind == CmpExec) && ExecReady) ||
                         ((r_kind == CmpIo) && IoReady);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state    <= StHalt;
            r_kind     <= CmpNow;
            r_ip_req   <= 1'b0;
            r_data_req <= 1'b0;
            r_ap_req   <= 1'b0;
            r_io_req   <= 1'b0;
            r_dec      <= 1'b0;
            r_io_dir   <= 1'b0;
            r_mode     <= 1'b1;
            r_cout     <= 1'b0;
            r_bp_hit   <= 1'b0;
            r_bp_skip  <= 1'b0;
            r_fault    <= 1'b0;
            r_steps    <= '0;
            r_wdog     <= '0;
        end else begin
            r_state    <= w_state_d;
            r_kind     <= w_kind_d;
            r_ip_req   <= w_ip_req_d;
            r_data_req <= w_data_req_d;
            r_ap_req   <= w_ap_req_d;
            r_io_req   <= w_io_req_d;
            r_dec      <= w_dec_d;
            r_io_dir   <= w_io_dir_d;
            r_mode     <= w_mode_d;
            r_cout     <= w_cout_d;
            r_bp_hit   <= w_bp_hit_d;
            r_bp_skip  <= w_bp_skip_d;
            r_fault    <= w_fault_d;
            r_steps    <= w_steps_d;
            r_wdog     <= w_wdog_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_kind_d     = r_kind;
        w_ip_req_d   = 1'b0;
        w_data_req_d = 1'b0;
        w_ap_req_d   = 1'b0;
        w_io_req_d   = 1'b0;
        w_dec_d      = r_dec;
        w_io_dir_d   = r_io_dir;
        w_mode_d     = r_mode;
        w_cout_d     = 1'b0;
        w_bp_hit_d   = r_bp_hit;
        w_bp_skip_d  = r_bp_skip;
        w_fault_d    = r_fault;
        w_steps_d    = r_steps;
        w_wdog_d     = '0;
        w_wait       = 1'b0;

        case (r_state)
            StHalt: begin
                if (Run || Step) begin
                    w_state_d   = StIdle;
                    w_bp_skip_d = 1'b1;
                    w_bp_hit_d  = 1'b0;
                    if (Run) begin
                        w_steps_d = '0;
                    end else begin
                        w_steps_d = (StepCount == '0) ? StepOne : StepCount;
                    end
                end
            end
            StIdle: begin
                if (Halt) begin
                    w_state_d = StHalt;
                end else begin
                    w_ip_req_d = 1'b1;
                    w_state_d  = StFetch;
                end
            end
            StFetch: begin
                if (!IpReady) begin
                    w_wait = 1'b1;
                end else if (BpEn && (IpAddress == BpAddr) && !r_bp_skip) begin
                    w_state_d  = StHalt;
                    w_bp_hit_d = 1'b1;
                end else begin
                    w_bp_skip_d = 1'b0;
                    w_state_d   = StExec;
                    w_kind_d    = CmpNow;
                    case (Insn[3:0])
                        4'b0001: begin
                            w_state_d = StHalt;
                            w_cout_d  = 1'b1;
                            if (r_steps != '0) w_steps_d = r_steps - StepOne;
                        end
                        4'b0010, 4'b0011: begin
                            if (r_mode) begin
                                w_data_req_d = 1'b1;
                                w_dec_d      = Insn[0];
                                w_kind_d     = CmpExec;
                            end
                        end
                        4'b0100, 4'b0101: begin
                            if (r_mode) begin
                                w_ap_req_d = 1'b1;
                                w_dec_d    = Insn[0];
                                w_kind_d   = CmpExec;
                            end
                        end
                        4'b0110: begin
                            if (w_loop_zero) begin
                                w_ip_req_d = 1'b1;
                                w_state_d  = StFetch;
                            end
                        end
                        4'b0111: begin
                            if (!w_loop_zero) begin
                                w_ip_req_d = 1'b1;
                                w_state_d  = StFetch;
                            end
                        end
                        4'b1000, 4'b1001: begin
                            w_io_req_d = 1'b1;
                            w_io_dir_d = Insn[0];
                            w_kind_d   = CmpIo;
                        end
                        4'b1110: w_mode_d = 1'b0;
                        4'b1111: w_mode_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            StExec: begin
                if (!w_done) begin
                    w_wait = 1'b1;
                end else begin
                    w_cout_d = 1'b1;
                    if (r_steps != '0) w_steps_d = r_steps - StepOne;
                    if (Halt || (r_steps == StepOne)) begin
                        w_state_d = StHalt;
                    end else begin
                        w_ip_req_d = 1'b1;
                        w_state_d  = StFetch;
                    end
                end
            end
            StFault: begin
                w_fault_d = 1'b1;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        // Watchdog: the last waiting cycle before the limit trips the sticky fault.
        if (w_wait) begin
            if (r_wdog == WdogLast) begin
                w_state_d = StFault;
                w_fault_d = 1'b1;
                w_wdog_d  = r_wdog;
            end else begin
                w_wdog_d = r_wdog + WdogOne;
            end
        end
    end

`ifdef DPC_IRET_EN
    logic [31:0] r_iret;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_iret <= '0;
        end else if (w_cout_d) begin
            r_iret <= r_iret + 32'd1;
        end
    end

    assign IRET = r_iret;
`endif

    assign State       = r_state;
    assign IpRequest   = r_ip_req;
    assign DataRequest = r_data_req;
    assign ApRequest   = r_ap_req;
    assign IoRequest   = r_io_req;
    assign Dec         = r_dec;
    assign IoDir       = r_io_dir;
    assign InsnMode    = r_mode;
    assign Cout        = r_cout;
    assign BpHit       = r_bp_hit;
    assign Fault       = r_fault;

endmodule

// File: doc/dpc_sequencer.md
Name: dpc_sequencer

Overview:
Parametrised next-generation control sequencer for the DekatronPC core. It fetches instructions from the IP line and dispatches them to the AP/data line and a new I/O unit. It adds bounded multi-step execution, an IP breakpoint, a handshake watchdog with sticky fault, and a fixed Halt priority. It sits at the top of the core between the operator controls (Halt/Step/Run) and the IpLine/ApLine/IO blocks.

Parameters:
INSN_WIDTH, 4, instruction width; only the low 4 bits are decoded, upper bits are ignored.
ADDR_WIDTH, 24, width of the BCD IP address (6 dekatrons x 4 bits).
STEP_WIDTH, 8, width of the step-count input and the internal steps-left counter.
TIMEOUT_W, 10, watchdog counter width; the limit is 2^TIMEOUT_W-1 cycles.

Ports:
Clk  in  1  system clock; all logic is on the rising edge.
Rst_n  in  1  asynchronous, active-low reset.
Halt, Step, Run  in  1 each  operator controls, level-sampled.
StepCount  in  STEP_WIDTH  number of instructions per Step; 0 is treated as 1.
BpEn  in  1  breakpoint enable.
BpAddr  in  ADDR_WIDTH  breakpoint IP address.
IpAddress  in  ADDR_WIDTH  current IP from the IP line.
IpRequest  out  1  one-cycle fetch/advance pulse.
IpReady  in  1  IP line has a valid Insn.
Insn  in  INSN_WIDTH  fetched instruction.
DataZero, ApZero  in  1 each  zero flags from the AP line.
DataRequest, ApRequest  out  1 each  one-cycle dispatch pulses.
Dec  out  1  direction for +-/<> (Insn[0]).
ExecReady  in  1  AP line done.
IoRequest  out  1  one-cycle I/O pulse.
IoDir  out  1  0 = output '.', 1 = input ','.
IoReady  in  1  I/O unit done.
InsnMode  out  1  1 = brainfuck ISA, 0 = debug ISA.
State  out  3  current state.
Cout  out  1  one-cycle retire strobe.
BpHit  out  1  high while halted on a breakpoint.
Fault  out  1  sticky watchdog fault.

Behaviour:
- Reset values: State=HALT; all requests, Dec, IoDir, Cout, BpHit, Fault = 0; InsnMode=1; StepsLeft=0; BpSkip=0; watchdog=0.
- State encodings: IDLE=001, FETCH=010, EXEC=011, HALT=100, FAULT=101. Any other code goes to IDLE next cycle.
- Loop flag: LoopZero = InsnMode ? DataZero : ApZero.
- HALT:
  - Run (wins over Step) -> IDLE, StepsLeft=0 (unbounded run).
  - Step -> IDLE, StepsLeft = max(StepCount,1).
  - Either exit sets BpSkip=1 and clears BpHit.
- IDLE: Halt -> HALT. Otherwise pulse IpRequest and go to FETCH. Halt has priority.
- FETCH: wait for IpReady; the watchdog counts every waiting cycle.
  - On IpReady with BpEn, IpAddress==BpAddr and BpSkip=0 -> HALT with BpHit=1; the instruction is not executed.
  - Otherwise clear BpSkip and decode the low 4 bits:
    - 0001: HALT, retired.
    - 001x: if InsnMode=1, DataRequest pulse, Dec=Insn[0]; else nop.
    - 010x: if InsnMode=1, ApRequest pulse, Dec=Insn[0]; else nop.
    - 0110 '[': if LoopZero, pulse IpRequest and stay in FETCH (IP line skips); else nop.
    - 0111 ']': if !LoopZero, pulse IpRequest and stay in FETCH; else nop.
    - 1000: IoRequest pulse, IoDir=0. 1001: IoRequest pulse, IoDir=1.
    - 1110: InsnMode=0. 1111: InsnMode=1.
    - Others: nop.
  - Non-HALT, non-loop-retry instructions -> EXEC. The watchdog clears on each IpReady.
- EXEC: completion condition:
  - ExecReady for dispatched +-/<>.
  - IoReady for I/O.
  - Immediate (the cycle after entry) for nop/mode/loop-fallthrough.
  - The watchdog counts while waiting.
  - On completion: Cout pulses for 1 cycle. If StepsLeft!=0, decrement it.
  - Then -> HALT if Halt, or if StepsLeft was 1. Otherwise pulse IpRequest and go to FETCH.
- Watchdog: at 2^TIMEOUT_W-1 waiting cycles in FETCH/EXEC -> FAULT.
- FAULT: Fault=1, all requests 0. Exits only by reset.
- Request pulses are exactly one cycle wide; no new request is issued before the matching ready.
- Reset mid-operation aborts immediately to HALT; no pending request survives.

Optional Feature:
- DPC_IRET_EN defined: adds output IRET [31:0], reset 0. It increments on every retire (Cout cycle, including the HALT insn) and wraps 0xFFFFFFFF->0.
- Undefined: the IRET port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, Run=1, program "+ + 0001", ExecReady returns 2 cycles after each DataRequest -> 2 DataRequest pulses with Dec=0, 3 Cout pulses, State=100; IRET=3 with DPC_IRET_EN.
- StepCount=3, Step pulse on an 8-nop program -> exactly 3 Cout pulses, then HALT; StepCount=0 -> 1 Cout.
- BpEn=1, BpAddr=000005, Run -> HALT with BpHit=1 when IpAddress=000005, no dispatch. Run again -> insn at 5 executes, no re-hit.
- Insn 0110 with DataZero=1, InsnMode=1 -> a second IpRequest in FETCH, no EXEC. Mode 1110 then 0110 uses ApZero.
- Hold ExecReady=0 after ApRequest with TIMEOUT_W=4 -> FAULT (101) after 15 cycles, Fault=1, stays until Rst_n low.
- Halt and IpReady in the same IDLE cycle -> HALT, no IpRequest issued.
